// File: rtl/regfile_mp_if.sv
// Bus bundle between the ID/WB stages and the multi-port register file.
// The register file takes the slave side; the pipeline drives the master side.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     init_done;

  modport master (
    output re, raddr, we, waddr, wdata, issue_en, issue_addr,
    input  rdata, rbusy, init_done
  );

  modport slave (
    input  re, raddr, we, waddr, wdata, issue_en, issue_addr,
    output rdata, rbusy, init_done
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, a per-register busy
// scoreboard, and a post-reset sequencer that zeroes every register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zeroing regs[ptr] one per cycle; writes/issue ignored, reads 0
// ST_READY | normal operation until the next reset
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];

  logic [ADDR_W-1:0]        rd_addr [NUM_RD];
  logic [NUM_RD-1:0]        bypass_hit;
  logic [DATA_W-1:0]        bypass_data [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Storage has no reset; the clear sequence is what guarantees zeros.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    regs_d  = regs_q;
    case (state_q)
      ST_CLEAR: begin
        regs_d[ptr_q] = '0;
        ptr_d         = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        // Ascending port order lets the youngest writer land last.
        for (int j = 0; j < NUM_WR; j++) begin
          if (bus.we[j] && !(ZERO_REG && bus.waddr[j*ADDR_W +: ADDR_W] == '0)) begin
            regs_d[bus.waddr[j*ADDR_W +: ADDR_W]] = bus.wdata[j*DATA_W +: DATA_W];
            busy_d[bus.waddr[j*ADDR_W +: ADDR_W]] = 1'b0;
          end
        end
        // A newly issued producer overrides a completing older one.
        if (bus.issue_en && !(ZERO_REG && bus.issue_addr == '0)) begin
          busy_d[bus.issue_addr] = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    rdata      = '0;
    rbusy      = '0;
    bypass_hit = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr[i]     = bus.raddr[i*ADDR_W +: ADDR_W];
      bypass_data[i] = '0;
      if (BYPASS) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (bus.we[j] && bus.waddr[j*ADDR_W +: ADDR_W] == rd_addr[i]) begin
            bypass_hit[i]  = 1'b1;
            bypass_data[i] = bus.wdata[j*DATA_W +: DATA_W];
          end
        end
      end
      if (state_q == ST_READY && bus.re[i] && !(ZERO_REG && rd_addr[i] == '0)) begin
        rdata[i*DATA_W +: DATA_W] = bypass_hit[i] ? bypass_data[i] : regs_q[rd_addr[i]];
        rbusy[i]                  = busy_q[rd_addr[i]] & ~bypass_hit[i];
      end
    end
  end

  assign bus.rdata     = rdata;
  assign bus.rbusy     = rbusy;
  assign bus.init_done = (state_q == ST_READY);
endmodule
